sprite_pixel_fetch: RTL and testbench

//  Downstream consumer of a sprite frame RAM (registered read, 1-cycle latency, 5-bit palette index out).
//  Per screen pixel: hit-tests DrawX/DrawY against the sprite box and drives the RAM read address.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sprite_anim_ctr.sv | 56 +++++
 rtl/sprite_pixel_fetch.sv | 108 ++++++++++
 tb/tb_sprite_pixel_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite geometry, widths and helpers for the sprite pixel fetch path.
package sprite_pkg;

    localparam int SPRITE_W    = 20;
    localparam int SPRITE_H    = 20;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;
    localparam int IDX_W       = 5;
    localparam int ADDR_W      = 19;

    typedef logic [9:0] coord_t;

    // Per-pixel side information carried alongside the RAM access.
    typedef struct packed {
        logic   valid;
        logic   hit;
        coord_t x;
        coord_t y;
    } pix_tag_t;

    // 11-bit unsigned span test: start <= pos < start + len, with no wraparound.
    function automatic logic in_span(input coord_t pos, input coord_t start, input logic [10:0] len);
        logic [10:0] p_ext;
        logic [10:0] s_ext;
        p_ext = {1'b0, pos};
        s_ext = {1'b0, start};
        return (p_ext >= s_ext) && (p_ext < (s_ext + len));
    endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation sequencer: divides frame_tick by ANIM_DIV and steps cur_frame modulo NUM_FRAMES.
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 1,
    parameter int ANIM_DIV   = 8,
    parameter int FRAME_W    = $clog2(NUM_FRAMES) + 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               anim_en,
    input  logic               frame_tick,
    output logic [FRAME_W-1:0] cur_frame
);

    localparam int TICK_W = $clog2(ANIM_DIV) + 1;

    logic [TICK_W-1:0]  tick_cnt_r;
    logic [TICK_W-1:0]  tick_nxt_s;
    logic [FRAME_W-1:0] frame_nxt_s;
    logic               advance_s;

    // Next-count logic; the frame only moves on a tick so it is stable over a visible frame.
    always_comb begin
        tick_nxt_s  = tick_cnt_r;
        frame_nxt_s = cur_frame;
        advance_s   = anim_en && frame_tick;
        if (advance_s) begin
            if (tick_cnt_r == TICK_W'(ANIM_DIV - 1)) begin
                tick_nxt_s = {TICK_W{1'b0}};
                if (cur_frame == FRAME_W'(NUM_FRAMES - 1)) begin
                    frame_nxt_s = {FRAME_W{1'b0}};
                end else begin
                    frame_nxt_s = cur_frame + FRAME_W'(1);
                end
            end else begin
                tick_nxt_s = tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_nxt_s  = tick_cnt_r;
            frame_nxt_s = cur_frame;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            cur_frame  <= {FRAME_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_nxt_s;
            cur_frame  <= frame_nxt_s;
        end
    end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: hit-tests each screen pixel, addresses the sprite RAM and
// aligns the returned palette index with the pixel coordinates (fixed 2-cycle latency).
module sprite_pixel_fetch
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 1,
    parameter int ANIM_DIV   = 8,
    parameter int TRANSP_IDX = 0
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          pix_valid,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    SpriteX,
    input  logic [9:0]                    SpriteY,
    input  logic                          flip_h,
    input  logic                          anim_en,
    input  logic                          frame_tick,
    input  logic [IDX_W-1:0]              ram_data,
    output logic [ADDR_W-1:0]             ram_read_address,
    output logic                          out_valid,
    output logic                          out_on,
    output logic [IDX_W-1:0]              out_idx,
    output logic [9:0]                    out_x,
    output logic [9:0]                    out_y,
    output logic [$clog2(NUM_FRAMES):0]   cur_frame
);

    localparam int FRAME_W = $clog2(NUM_FRAMES) + 1;

    logic              hit_s;
    logic [10:0]       col_raw_s;
    logic [10:0]       col_s;
    logic [10:0]       row_s;
    logic [ADDR_W-1:0] addr_s;
    pix_tag_t          tag_s;
    pix_tag_t          tag1_r;
    pix_tag_t          tag2_r;
    logic              on_s;
    logic [IDX_W-1:0]  idx_s;

    sprite_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV),
        .FRAME_W    (FRAME_W)
    ) u_anim (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .anim_en    (anim_en),
        .frame_tick (frame_tick),
        .cur_frame  (cur_frame)
    );

    // Hit test and RAM address for the pixel presented this cycle.
    always_comb begin
        hit_s = pix_valid
              && in_span(DrawX, SpriteX, 11'(SPRITE_W))
              && in_span(DrawY, SpriteY, 11'(SPRITE_H));
        col_raw_s = {1'b0, DrawX} - {1'b0, SpriteX};
        if (flip_h) begin
            col_s = 11'(SPRITE_W - 1) - col_raw_s;
        end else begin
            col_s = col_raw_s;
        end
        row_s  = {1'b0, DrawY} - {1'b0, SpriteY};
        addr_s = ADDR_W'(cur_frame) * ADDR_W'(FRAME_WORDS)
               + ADDR_W'(row_s) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col_s);
        tag_s  = '{valid: pix_valid, hit: hit_s, x: DrawX, y: DrawY};
    end

    // Output decode once the RAM word for the stage-2 pixel is on ram_data.
    always_comb begin
        on_s = tag2_r.hit && (ram_data != IDX_W'(TRANSP_IDX));
        if (on_s) begin
            idx_s = ram_data;
        end else begin
            idx_s = {IDX_W{1'b0}};
        end
    end

    // Address register (holds on a miss) and the two-stage alignment pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_read_address <= {ADDR_W{1'b0}};
            tag1_r           <= '0;
            tag2_r           <= '0;
            out_valid        <= 1'b0;
            out_on           <= 1'b0;
            out_idx          <= {IDX_W{1'b0}};
            out_x            <= 10'd0;
            out_y            <= 10'd0;
        end else begin
            if (hit_s) begin
                ram_read_address <= addr_s;
            end
            tag1_r    <= tag_s;
            tag2_r    <= tag1_r;
            out_valid <= tag2_r.valid;
            out_on    <= on_s;
            out_idx   <= idx_s;
            out_x     <= tag2_r.x;
            out_y     <= tag2_r.y;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch (two animation frames, divide-by-2 animation).
module tb_sprite_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [9:0]  draw_x, draw_y, sprite_x, sprite_y;
    logic        flip_h, anim_en, frame_tick;
    logic [4:0]  ram_data;
    logic [18:0] ram_read_address;
    logic        out_valid, out_on;
    logic [4:0]  out_idx;
    logic [9:0]  out_x, out_y;
    logic [1:0]  cur_frame;

    typedef struct {
        logic       valid;
        logic       on;
        logic [4:0] idx;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] mem [0:1023];
    int         m_addr, m_frame, m_tick;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    sprite_pixel_fetch #(
        .NUM_FRAMES (2),
        .ANIM_DIV   (2),
        .TRANSP_IDX (0)
    ) dut (
        .Clk              (clk),
        .Reset_n          (rst_n),
        .pix_valid        (pix_valid),
        .DrawX            (draw_x),
        .DrawY            (draw_y),
        .SpriteX          (sprite_x),
        .SpriteY          (sprite_y),
        .flip_h           (flip_h),
        .anim_en          (anim_en),
        .frame_tick       (frame_tick),
        .ram_data         (ram_data),
        .ram_read_address (ram_read_address),
        .out_valid        (out_valid),
        .out_on           (out_on),
        .out_idx          (out_idx),
        .out_x            (out_x),
        .out_y            (out_y),
        .cur_frame        (cur_frame)
    );

    always #5 clk = ~clk;

    // Sprite frame RAM: registered read, one cycle of latency.
    always @(posedge clk) ram_data <= mem[ram_read_address[9:0]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic push_zero();
        exp_t z;
        z.valid = 1'b0; z.on = 1'b0; z.idx = 5'd0; z.x = 10'd0; z.y = 10'd0;
        sb.push_back(z);
    endtask

    task automatic set_pix(input logic v, input int x, input int y, input logic f);
        pix_valid = v;
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        flip_h    = f;
    endtask

    // One clock: model the sampled pixel, then compare address, frame and aligned outputs.
    task automatic step();
        exp_t e;
        int   dx, dy, sx, sy, col, row;
        logic hit;
        @(posedge clk);
        dx = int'(draw_x); dy = int'(draw_y); sx = int'(sprite_x); sy = int'(sprite_y);
        hit = pix_valid && dx >= sx && dx < sx + 20 && dy >= sy && dy < sy + 20;
        if (hit) begin
            col = flip_h ? (19 - (dx - sx)) : (dx - sx);
            row = dy - sy;
            m_addr = m_frame * 400 + row * 20 + col;
        end
        e.valid = pix_valid;
        e.on    = hit && (mem[m_addr] != 5'd0);
        e.idx   = e.on ? mem[m_addr] : 5'd0;
        e.x     = draw_x;
        e.y     = draw_y;
        sb.push_back(e);
        if (anim_en && frame_tick) begin
            if (m_tick == 1) begin
                m_tick  = 0;
                m_frame = (m_frame == 1) ? 0 : 1;
            end else begin
                m_tick++;
            end
        end
        #1;
        check_eq("addr", 32'(ram_read_address), 32'(m_addr));
        check_eq("cur_frame", 32'(cur_frame), 32'(m_frame));
        if (sb.size() > 2) begin
            e = sb.pop_front();
            check_eq("out_valid", 32'(out_valid), 32'(e.valid));
            check_eq("out_on", 32'(out_on), 32'(e.on));
            check_eq("out_idx", 32'(out_idx), 32'(e.idx));
            check_eq("out_x", 32'(out_x), 32'(e.x));
            check_eq("out_y", 32'(out_y), 32'(e.y));
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic model_reset();
        m_addr = 0; m_frame = 0; m_tick = 0;
        sb.delete();
        push_zero();
        push_zero();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 5'((i * 7 + 1) % 32);
        mem[45] = 5'd3;
        mem[46] = 5'd0;
        rst_n = 1'b0;
        set_pix(1'b0, 0, 0, 1'b0);
        sprite_x = 10'd100; sprite_y = 10'd50;
        anim_en = 1'b0; frame_tick = 1'b0;
        model_reset();
        #3;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_addr", 32'(ram_read_address), 32'd0);
        check_eq("rst_frame", 32'(cur_frame), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic hit, mirrored hit, box-edge misses, transparent hit.
        set_pix(1'b1, 105, 52, 1'b0); step();
        check_eq("addr_plain", 32'(ram_read_address), 32'd45);
        set_pix(1'b1, 105, 52, 1'b1); step();
        check_eq("addr_flip", 32'(ram_read_address), 32'd54);
        set_pix(1'b1, 99, 52, 1'b0);  step();
        set_pix(1'b1, 120, 52, 1'b0); step();
        check_eq("addr_hold", 32'(ram_read_address), 32'd54);
        set_pix(1'b1, 106, 52, 1'b0); step();
        set_pix(1'b1, 119, 69, 1'b0); step();
        set_pix(1'b1, 100, 70, 1'b0); step();
        set_pix(1'b0, 0, 0, 1'b0);    step(); step(); step();

        // Randomised scan around a moving box, including the raster edge.
        for (int i = 0; i < 200; i++) begin
            if (i % 40 == 0) begin
                sprite_x = (i == 120) ? 10'd630 : 10'($urandom_range(0, 600));
                sprite_y = (i == 160) ? 10'd470 : 10'($urandom_range(0, 450));
            end
            frame_tick = 1'($urandom_range(0, 1));
            set_pix(1'($urandom_range(0, 3) != 0),
                    int'(sprite_x) + $urandom_range(0, 25) - 3,
                    int'(sprite_y) + $urandom_range(0, 25) - 3,
                    1'($urandom_range(0, 1)));
            step();
        end
        frame_tick = 1'b0;

        // Animation sequencing and frame-1 addressing.
        sprite_x = 10'd100; sprite_y = 10'd50;
        set_pix(1'b0, 0, 0, 1'b0);
        anim_en = 1'b1;
        pulse_tick();
        check_eq("frame_1tick", 32'(cur_frame), 32'd0);
        pulse_tick();
        check_eq("frame_2tick", 32'(cur_frame), 32'd1);
        set_pix(1'b1, 100, 50, 1'b0); step();
        check_eq("addr_frame1", 32'(ram_read_address), 32'd400);
        set_pix(1'b0, 0, 0, 1'b0);
        pulse_tick(); pulse_tick();
        check_eq("frame_wrap", 32'(cur_frame), 32'd0);
        pulse_tick(); pulse_tick();
        anim_en = 1'b0;
        pulse_tick(); pulse_tick(); pulse_tick();
        check_eq("frame_frozen", 32'(cur_frame), 32'd1);

        // Reset in the middle of a pixel stream.
        for (int i = 0; i < 6; i++) begin
            set_pix(1'b1, 101 + i, 51, 1'b0); step();
        end
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_on", 32'(out_on), 32'd0);
        check_eq("mid_rst_addr", 32'(ram_read_address), 32'd0);
        check_eq("mid_rst_frame", 32'(cur_frame), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_pix(1'b1, 110 + i, 60, 1'(i % 2)); step();
        end
        set_pix(1'b0, 0, 0, 1'b0);
        step(); step(); step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
